vga_sync_generator: RTL



---
 rtl/vga_sync_generator.sv | 134 +++++++++++++
 1 files changed

// File: rtl/vga_sync_generator.sv
// vga_sync_generator
//   640x480@60 VGA timing from the 25 MHz pixel clock. Issues one pixel
//   request per cycle to an upstream source and delay-aligns the returned RGB
//   with HS/VS/BLANK_N so every output leaves the same register stage.
// Ports:
//   CLOCK_25              pixel clock, rising edge only
//   SW                    synchronous active-high reset
//   In_R/In_G/In_B        upstream RGB, valid PIPE cycles after Req_Valid
//   Req_Valid/X/Y         pixel request (X/Y also count through blanking)
//   Frame_Start           one-cycle pulse alongside the request for (0,0)
//   VGA_HS/VS             active-low syncs
//   VGA_BLANK_N           high on visible pixels
//   VGA_R/G/B             RGB to DAC, zero while blanked
module vga_sync_generator #(
  parameter int PIPE     = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       CLOCK_25,
  input  logic       SW,
  input  logic [7:0] In_R,
  input  logic [7:0] In_G,
  input  logic [7:0] In_B,
  output logic       Req_Valid,
  output logic [9:0] Req_X,
  output logic [9:0] Req_Y,
  output logic       Frame_Start,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic vld;
    logic hs_n;
    logic vs_n;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{vld: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [9:0]  req_x_q, req_x_d, req_y_q, req_y_d;
  logic        fs_q, fs_d;
  // Entry 0 is the request stage; entries 1..PIPE track the upstream latency.
  sync_t       sync_pipe_q [PIPE:0];
  sync_t       sync_pipe_d [PIPE:0];
  sync_t       vd;
  logic        blank_n_q, blank_n_d, hs_q, hs_d, vs_q, vs_d;
  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end

    req_x_d = h_q;
    req_y_d = v_q;
    fs_d    = (h_q == '0) && (v_q == '0);

    sync_pipe_d[0].vld  = (h_q < H_ACT) && (v_q < V_ACT);
    sync_pipe_d[0].hs_n = !((h_q >= HS_BEG) && (h_q < HS_END));
    sync_pipe_d[0].vs_n = !((v_q >= VS_BEG) && (v_q < VS_END));
    for (int i = 1; i <= PIPE; i++) sync_pipe_d[i] = sync_pipe_q[i-1];

    // With PIPE=0 the tap is the request stage itself.
    vd        = sync_pipe_q[PIPE];
    blank_n_d = vd.vld;
    hs_d      = vd.hs_n;
    vs_d      = vd.vs_n;
    rgb_d     = vd.vld ? {In_R, In_G, In_B} : 24'd0;
  end

  always_ff @(posedge CLOCK_25) begin
    if (SW) begin
      h_q       <= '0;
      v_q       <= '0;
      req_x_q   <= '0;
      req_y_q   <= '0;
      fs_q      <= 1'b0;
      for (int i = 0; i <= PIPE; i++) sync_pipe_q[i] <= SYNC_IDLE;
      blank_n_q <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      rgb_q     <= '0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      req_x_q   <= req_x_d;
      req_y_q   <= req_y_d;
      fs_q      <= fs_d;
      for (int i = 0; i <= PIPE; i++) sync_pipe_q[i] <= sync_pipe_d[i];
      blank_n_q <= blank_n_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      rgb_q     <= rgb_d;
    end
  end

  assign Req_Valid   = sync_pipe_q[0].vld;
  assign Req_X       = req_x_q;
  assign Req_Y       = req_y_q;
  assign Frame_Start = fs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];

endmodule
